seq_detector_1010: RTL and testbench

Serial bit-pattern detector, Mealy style. It watches a 1-bit input stream sampled once per clock and asserts a one-cycle flag on the same cycle the final bit of the pattern (default 1010) is present. It sits in the serial-input front end, after bit synchronisation, and feeds event counters and interrupt logic. Detection can be overlapping or non-overlapping; a compile-time option adds a registered output.

---
 rtl/seq_detector_1010.sv | 138 +++++++++++++
 tb/tb_seq_detector_1010.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_detector_1010.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_1010
//  Purpose  : Mealy serial bit-pattern detector. Watches a 1-bit stream
//             sampled on every rising clock edge. It flags (y=1) the cycle in
//             which the final bit of PATTERN is on t. Detection is overlapping
//             or non-overlapping, selected by OVERLAP. The state-transition
//             table is derived from PATTERN/LEN at elaboration time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PATTERN [LEN-1:0] : target sequence, MSB is the first bit received
//    LEN               : pattern length in bits (2..16)
//    OVERLAP           : 1 = overlapping detection, 0 = non-overlapping
//  Ports
//    clk   in  1 : clock, rising edge
//    rst_n in  1 : synchronous reset, ACTIVE-HIGH despite the name
//    t     in  1 : serial data bit
//    y     out 1 : detect flag
//  Compile-time option
//    SEQ_DET_REG_OUT_EN : when defined, y is taken from a flip-flop. The flop
//                         captures the detect term, so y asserts one cycle
//                         after the final bit was sampled.
// ============================================================================
module seq_detector_1010 #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1010,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic y
);

    // State k means that the last k received bits equal the first k bits of
    // PATTERN. Only 0..LEN-1 are legal. The table is padded to a power of two
    // so that any illegal encoding indexes an entry that returns to S0.
    localparam int         c_SW   = (LEN > 2) ? $clog2(LEN) : 1;
    localparam int         c_NS   = 1 << c_SW;
    localparam logic [c_SW-1:0] c_S0   = '0;
    localparam logic [c_SW-1:0] c_LAST = c_SW'(LEN - 1);

    // Next state from state k on input bit b. Build the received string
    // s[0..k]: the first k pattern bits, followed by b. On a plain prefix
    // extension the result is k+1. Otherwise the result is the longest
    // proper suffix of s that is also a prefix of PATTERN. A full match
    // falls into the same suffix search, which gives the overlap restart
    // state. Non-overlapping detection restarts from S0 instead.
    function automatic int f_next(input int k, input logic b);
        logic [16:0] s;
        int          best;
        logic        ok;
        best = 0;
        s    = '0;
        if ((k < LEN - 1) && (b == PATTERN[LEN-1-k])) begin
            best = k + 1;
        end else if ((k == LEN - 1) && (b == PATTERN[0]) && !OVERLAP) begin
            best = 0;
        end else begin
            for (int i = 0; i < k; i++) begin
                s[i] = PATTERN[LEN-1-i];
            end
            s[k] = b;
            for (int j = 1; j <= k; j++) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (s[k+1-j+i] != PATTERN[LEN-1-i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    logic [c_SW-1:0] w_nxt0 [c_NS];
    logic [c_SW-1:0] w_nxt1 [c_NS];

    generate
        for (genvar k = 0; k < c_NS; k++) begin : g_tbl
            if (k < LEN) begin : g_legal
                assign w_nxt0[k] = c_SW'(f_next(k, 1'b0));
                assign w_nxt1[k] = c_SW'(f_next(k, 1'b1));
            end else begin : g_illegal
                assign w_nxt0[k] = c_S0;
                assign w_nxt1[k] = c_S0;
            end
        end
    endgenerate

    logic [c_SW-1:0] r_state;
    logic [c_SW-1:0] w_next;
    logic            w_hit;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= c_S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_nxt0[r_state];
        w_hit  = 1'b0;
        if (t) begin
            w_next = w_nxt1[r_state];
        end
        // Illegal states can never equal c_LAST, so they never flag.
        if ((r_state == c_LAST) && (t == PATTERN[0])) begin
            w_hit = 1'b1;
        end
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic r_y;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_hit;
        end
    end

    assign y = r_y;
`else
    // The flag is suppressed during reset, including the cycle in which
    // reset is first asserted, even if the old state would match.
    assign y = w_hit & ~rst_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_1010.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_1010
//  Purpose  : Scoreboard bench for seq_detector_1010. One instance uses
//             overlapping detection and one uses non-overlapping detection.
//             Both receive the same stream. The driver pushes hand-computed
//             expectations into one queue per instance. A monitor pops each
//             queue on the falling edge and compares the entry against y.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_1010;

    logic clk;
    logic rst_n;
    logic t;
    logic y_ov;
    logic y_nov;

    int   n_tests;
    int   n_fail;

    logic q_ov[$];
    logic q_nov[$];

    // Previous-cycle detect terms. These model the output flop when the
    // registered-output build is selected.
    logic r_prev_ov;
    logic r_prev_nov;

    seq_detector_1010 #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) dut_ov (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .y     (y_ov)
    );

    seq_detector_1010 #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) dut_nov (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .y     (y_nov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit for one cycle. e_ov and e_nov are the combinational
    // (Mealy) expectations for that cycle.
    task automatic step(input logic r, input logic b, input logic e_ov, input logic e_nov);
        @(posedge clk);
        #1;
        rst_n = r;
        t     = b;
`ifdef SEQ_DET_REG_OUT_EN
        q_ov.push_back(r_prev_ov);
        q_nov.push_back(r_prev_nov);
        r_prev_ov  = r ? 1'b0 : e_ov;
        r_prev_nov = r ? 1'b0 : e_nov;
`else
        q_ov.push_back(e_ov);
        q_nov.push_back(e_nov);
`endif
    endtask

    // Drive n bits, MSB first. Each expectation mask uses the same bit order.
    task automatic run_seq(input logic [15:0] bits, input int n,
                           input logic [15:0] m_ov, input logic [15:0] m_nov);
        for (int i = 0; i < n; i++) begin
            step(1'b0, bits[n-1-i], m_ov[n-1-i], m_nov[n-1-i]);
        end
    endtask

    // Monitor: y is valid every cycle, so pop and compare once per cycle.
    always @(negedge clk) begin
        logic e;
        if (q_ov.size() > 0) begin
            e = q_ov.pop_front();
            n_tests++;
            if (y_ov !== e) begin
                n_fail++;
                $display("FAIL y_overlap @%0t: got %b, expected %b", $time, y_ov, e);
            end
        end
        if (q_nov.size() > 0) begin
            e = q_nov.pop_front();
            n_tests++;
            if (y_nov !== e) begin
                n_fail++;
                $display("FAIL y_nonoverlap @%0t: got %b, expected %b", $time, y_nov, e);
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        r_prev_ov  = 1'b0;
        r_prev_nov = 1'b0;
        rst_n      = 1'b1;
        t          = 1'b0;

        // Reset: hold for two cycles with t=0.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Overlap stream 1,1,0,1,0,1,0,1,0,1,0.
        // Overlapping detection flags bits 5, 7, 9 and 11.
        // Non-overlapping detection flags bits 5 and 9.
        run_seq(16'b11010101010, 11, 16'b00001010101, 16'b00001000100);

        // Mid-pattern reset. Clear first, then drive 1,0,1 to reach S3.
        // Reset is asserted with t=0, which would complete the pattern, but
        // y must stay 0. Then drive 0, which must not flag.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(16'b101, 3, 16'b000, 16'b000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(16'b1010, 4, 16'b0001, 16'b0001);

        // Near-miss: 1,0,0,1,0,1,1,0,1,0 flags bit 10 only.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(16'b1001011010, 10, 16'b0000000001, 16'b0000000001);

        // Back-to-back 1010 1010. Overlapping detection flags bits 4, 6
        // and 8. Non-overlapping detection flags bits 4 and 8.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(16'b10101010, 8, 16'b00010101, 16'b00010001);

        // Let the monitor drain the final entries, with a bounded wait.
        for (int c = 0; c < 4 && (q_ov.size() > 0 || q_nov.size() > 0); c++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (q_ov.size() != 0 || q_nov.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", q_ov.size(), q_nov.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
